// File: rtl/fifo_pkt_writer.sv
// Packet writer: streams source bytes into a FIFO through a one-byte holding register,
// appends an optional XOR checksum trailer and truncates packets longer than MAX_LEN.
module fifo_pkt_writer #(
    parameter int unsigned CSUM_EN = 1,
    parameter int unsigned MAX_LEN = 16
) (
    input  logic       wr_clk,
    input  logic       reset_n,
    input  logic       i_src_valid,
    input  logic [7:0] i_src_data,
    input  logic       i_src_last,
    output logic       o_src_ready,
    input  logic       i_fifo_full,
    output logic       o_fifo_wr,
    output logic [7:0] o_fifo_data,
    output logic [7:0] o_byte_count,
    output logic       o_pkt_done,
    output logic       o_too_long
);

    localparam logic       CsumEn = (CSUM_EN != 0);
    localparam logic [7:0] MaxLen = MAX_LEN[7:0];

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StCsum,
        StDrop
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    logic [7:0] r_hold_data;
    logic       r_hold_valid;
    logic       r_hold_last;
    logic       r_hold_is_csum;
    logic [7:0] r_csum;
    logic [7:0] r_acc_cnt;
    logic [7:0] r_byte_count;
    logic       r_pkt_done;
    logic       r_too_long;

    logic [7:0] w_hold_data_nxt;
    logic       w_hold_valid_nxt;
    logic       w_hold_last_nxt;
    logic       w_hold_is_csum_nxt;
    logic [7:0] w_csum_nxt;
    logic [7:0] w_acc_cnt_nxt;
    logic [7:0] w_byte_count_nxt;

    logic       w_wr;
    logic       w_data_wr;
    logic       w_xfer;
    logic       w_xfer_data;
    logic       w_start;
    logic       w_trunc;
    logic       w_hold_takes_csum;
    logic       w_last_data_wr;
    logic       w_final_wr;
    logic [7:0] w_new_cnt;
    logic [7:0] w_csum_upd;

    assign w_wr        = r_hold_valid & ~i_fifo_full;
    assign w_data_wr   = w_wr & ~r_hold_is_csum;
    assign o_fifo_wr   = w_wr;
    assign o_fifo_data = r_hold_data;

    // A held last data byte must be replaced by the checksum, so no new byte may enter behind it.
    assign w_hold_takes_csum = CsumEn & r_hold_valid & r_hold_last & ~r_hold_is_csum;

    always_comb begin
        o_src_ready = 1'b0;
        unique case (r_state)
            StIdle, StData: o_src_ready = (~r_hold_valid | w_wr) & ~w_hold_takes_csum;
            StDrop:         o_src_ready = 1'b1;
            StCsum:         o_src_ready = 1'b0;
            default:        o_src_ready = 1'b0;
        endcase
    end

    assign w_xfer      = i_src_valid & o_src_ready;
    assign w_xfer_data = w_xfer & ((r_state == StIdle) | (r_state == StData));
    // In DATA a transfer behind an already-held last byte belongs to the next packet.
    assign w_start     = w_xfer_data &
                         ((r_state == StIdle) | (r_hold_valid & r_hold_last));
    assign w_new_cnt   = w_start ? 8'd1 : r_acc_cnt + 8'd1;
    assign w_trunc     = w_xfer_data & ~i_src_last & (w_new_cnt == MaxLen);

    assign w_last_data_wr = w_wr & r_hold_last & ~r_hold_is_csum;
    assign w_final_wr     = w_wr & r_hold_last & (r_hold_is_csum | ~CsumEn);
    assign w_csum_upd     = r_csum ^ r_hold_data;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_xfer) begin
                    w_state_nxt = w_trunc ? StDrop : StData;
                end
            end
            StData: begin
                if (w_last_data_wr) begin
                    if (CsumEn) begin
                        w_state_nxt = StCsum;
                    end else if (w_xfer) begin
                        w_state_nxt = w_trunc ? StDrop : StData;
                    end else begin
                        w_state_nxt = StIdle;
                    end
                end else if (w_trunc) begin
                    w_state_nxt = StDrop;
                end
            end
            StCsum: begin
                if (w_wr) begin
                    w_state_nxt = StIdle;
                end
            end
            StDrop: begin
                if (w_xfer && i_src_last) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // Hold register runs independently of the state so a truncated packet drains during DROP.
    always_comb begin
        w_hold_data_nxt    = r_hold_data;
        w_hold_valid_nxt   = r_hold_valid;
        w_hold_last_nxt    = r_hold_last;
        w_hold_is_csum_nxt = r_hold_is_csum;
        if (w_xfer_data) begin
            w_hold_data_nxt    = i_src_data;
            w_hold_valid_nxt   = 1'b1;
            w_hold_last_nxt    = i_src_last | w_trunc;
            w_hold_is_csum_nxt = 1'b0;
        end else if (w_last_data_wr && CsumEn) begin
            w_hold_data_nxt    = w_csum_upd;
            w_hold_valid_nxt   = 1'b1;
            w_hold_last_nxt    = 1'b1;
            w_hold_is_csum_nxt = 1'b1;
        end else if (w_wr) begin
            w_hold_valid_nxt   = 1'b0;
        end
    end

    always_comb begin
        w_csum_nxt = r_csum;
        if (w_start) begin
            w_csum_nxt = 8'd0;
        end else if (w_data_wr) begin
            w_csum_nxt = w_csum_upd;
        end
    end

    assign w_acc_cnt_nxt    = w_xfer_data ? w_new_cnt : r_acc_cnt;
    // The count clears on the edge after pkt_done, while still counting a new packet's first write.
    assign w_byte_count_nxt = (r_pkt_done ? 8'd0 : r_byte_count) + {7'd0, w_data_wr};

    always_ff @(posedge wr_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= StIdle;
            r_hold_data    <= 8'd0;
            r_hold_valid   <= 1'b0;
            r_hold_last    <= 1'b0;
            r_hold_is_csum <= 1'b0;
            r_csum         <= 8'd0;
            r_acc_cnt      <= 8'd0;
            r_byte_count   <= 8'd0;
            r_pkt_done     <= 1'b0;
            r_too_long     <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_hold_data    <= w_hold_data_nxt;
            r_hold_valid   <= w_hold_valid_nxt;
            r_hold_last    <= w_hold_last_nxt;
            r_hold_is_csum <= w_hold_is_csum_nxt;
            r_csum         <= w_csum_nxt;
            r_acc_cnt      <= w_acc_cnt_nxt;
            r_byte_count   <= w_byte_count_nxt;
            r_pkt_done     <= w_final_wr;
            r_too_long     <= w_trunc;
        end
    end

    assign o_byte_count = r_byte_count;
    assign o_pkt_done   = r_pkt_done;
    assign o_too_long   = r_too_long;

endmodule
